mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : HI/LO multiply/divide unit controller for the E stage.
//               Accepts mult/multu/div/divu as multi-cycle operations (5 cycles
//               for multiplies, 10 for divides), mthi/mtlo as single-edge
//               writes, and raises a pipeline stall while a D-stage HI/LO
//               instruction would collide with an operation in flight.
//
// Ports
//   clk       in   1   pipeline clock, rising-edge active
//   reset     in   1   asynchronous, active-low reset
//   md_op     in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                      6 mtlo, 7 reserved (no-op)
//   md_valid  in   1   md_op is live this cycle
//   rs_val    in  32   multiplicand / dividend / mthi-mtlo source
//   rt_val    in  32   multiplier / divisor
//   D_useMd   in   1   D-stage instruction touches HI/LO
//   hi        out 32   architectural HI
//   lo        out 32   architectural LO
//   busy      out  1   multi-cycle operation in flight
//   stall_md  out  1   contribution to the pipeline stall term
//
// Revision    : 1.0  initial release
// ============================================================================
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic        md_valid,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        D_useMd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_OP_NONE  = 3'd0;
    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [3:0] c_MULT_CYCLES = 4'd5;
    localparam logic [3:0] c_DIV_CYCLES  = 4'd10;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [0:0]  w_nextState;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // ------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------
    logic w_isIdle;
    logic w_isLongOp;
    logic w_isDivIssue;
    logic w_start;
    logic w_mtHi;
    logic w_mtLo;
    logic w_finish;

    assign w_isIdle     = (r_state == c_ST_IDLE);
    assign w_isLongOp   = (md_op == c_OP_MULT) || (md_op == c_OP_MULTU) ||
                          (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);
    assign w_isDivIssue = (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);

    // Any op seen while BUSY is dropped: every issue term is gated by IDLE.
    assign w_start  = md_valid && w_isLongOp && w_isIdle;
    assign w_mtHi   = md_valid && (md_op == c_OP_MTHI) && w_isIdle;
    assign w_mtLo   = md_valid && (md_op == c_OP_MTLO) && w_isIdle;

    // The last busy edge is the one at which the counter still reads 1.
    assign w_finish = (r_state == c_ST_BUSY) && (r_cnt == 4'd1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_nextState = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (w_finish) begin
                    w_nextState = c_ST_IDLE;
                end
            end
            default: w_nextState = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        case (r_state)
            c_ST_BUSY: busy = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

    // The start term is included so the instruction behind a fresh
    // mult/div is held in D during the issue cycle itself.
    assign stall_md = D_useMd && (busy || w_start);

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    logic signed [63:0] w_prodS;
    logic        [63:0] w_prodU;

    assign w_prodS = $signed({{32{r_opA[31]}}, r_opA}) * $signed({{32{r_opB[31]}}, r_opB});
    assign w_prodU = {32'd0, r_opA} * {32'd0, r_opB};

    // Signed division runs on magnitudes and fixes the signs afterwards.
    // This also yields the required overflow case for free:
    // |0x80000000| / 1 = 0x80000000 with a positive sign, remainder 0.
    logic        w_divSigned;
    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [31:0] w_quoMag;
    logic [31:0] w_remMag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_divZero;

    assign w_divSigned = (r_op == c_OP_DIV);
    assign w_negA      = w_divSigned && r_opA[31];
    assign w_negB      = w_divSigned && r_opB[31];
    assign w_magA      = w_negA ? (32'd0 - r_opA) : r_opA;
    assign w_magB      = w_negB ? (32'd0 - r_opB) : r_opB;
    assign w_divZero   = (r_opB == 32'd0);
    // The divisor is forced non-zero here only to keep the divider free of
    // a zero operand; a zero divisor never reaches HI/LO anyway.
    assign w_quoMag    = w_magA / (w_divZero ? 32'd1 : w_magB);
    assign w_remMag    = w_magA % (w_divZero ? 32'd1 : w_magB);
    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign w_quo       = (w_negA ^ w_negB) ? (32'd0 - w_quoMag) : w_quoMag;
    assign w_rem       = w_negA ? (32'd0 - w_remMag) : w_remMag;

    logic [31:0] w_resHi;
    logic [31:0] w_resLo;
    logic        w_resWrite;

    always_comb begin
        w_resHi    = r_hi;
        w_resLo    = r_lo;
        w_resWrite = 1'b0;
        case (r_op)
            c_OP_MULT: begin
                w_resHi    = w_prodS[63:32];
                w_resLo    = w_prodS[31:0];
                w_resWrite = 1'b1;
            end
            c_OP_MULTU: begin
                w_resHi    = w_prodU[63:32];
                w_resLo    = w_prodU[31:0];
                w_resWrite = 1'b1;
            end
            c_OP_DIV, c_OP_DIVU: begin
                w_resHi    = w_rem;
                w_resLo    = w_quo;
                // Divide by zero runs its full length but leaves HI/LO alone.
                w_resWrite = !w_divZero;
            end
            default: begin
                w_resWrite = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, cycle counter and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_op  <= c_OP_NONE;
            r_opA <= 32'd0;
            r_opB <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_start) begin
                r_op  <= md_op;
                r_opA <= rs_val;
                r_opB <= rt_val;
                r_cnt <= w_isDivIssue ? c_DIV_CYCLES : c_MULT_CYCLES;
            end else if (r_state == c_ST_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_finish && w_resWrite) begin
                r_hi <= w_resHi;
                r_lo <= w_resLo;
            end

            if (w_mtHi) begin
                r_hi <= rs_val;
            end
            if (w_mtLo) begin
                r_lo <= rs_val;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl. Directed corner cases
//               followed by randomized HI/LO operations, compared against a
//               64-bit arithmetic reference model of HI/LO.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic        md_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        D_useMd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    int          nChecks = 0;
    int          nFail   = 0;
    logic [31:0] expHi   = 32'd0;
    logic [31:0] expLo   = 32'd0;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .md_valid (md_valid),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .D_useMd  (D_useMd),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall_md (stall_md)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // HI/LO effect of one completed long operation, in plain 64-bit math.
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        longint          sq;
        longint          sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin
                sp = sa * sb;
                expHi = sp[63:32];
                expLo = sp[31:0];
            end
            3'd2: begin
                up = ua * ub;
                expHi = up[63:32];
                expLo = up[31:0];
            end
            3'd3: begin
                if (b != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    expLo = sq[31:0];
                    expHi = sr[31:0];
                end
            end
            3'd4: begin
                if (b != 32'd0) begin
                    expLo = a / b;
                    expHi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one long op, walk its busy window, then check the result.
    // injectAt >= 0 fires a stray HI/LO op at that busy cycle.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic useMd, input int injectAt);
        int          len;
        logic [31:0] oldHi;
        logic [31:0] oldLo;
        len   = (op >= 3'd3) ? 10 : 5;
        oldHi = expHi;
        oldLo = expLo;
        md_valid = 1'b1;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        D_useMd  = useMd;
        #1;
        check("stall_on_start", {31'd0, stall_md}, {31'd0, useMd});
        check("busy_on_start", {31'd0, busy}, 32'd0);
        stepEdge();
        for (int i = 0; i < len; i++) begin
            if (i == injectAt) begin
                md_valid = 1'b1;
                md_op    = 3'($urandom_range(1, 6));
            end else begin
                md_valid = 1'b0;
                md_op    = 3'($urandom);
            end
            rs_val = $urandom;
            rt_val = $urandom;
            #1;
            check("busy_window", {31'd0, busy}, 32'd1);
            check("stall_window", {31'd0, stall_md}, {31'd0, useMd});
            check("hi_during_busy", hi, oldHi);
            check("lo_during_busy", lo, oldLo);
            stepEdge();
        end
        md_valid = 1'b0;
        refModel(op, a, b);
        #1;
        check("busy_after", {31'd0, busy}, 32'd0);
        check("stall_after", {31'd0, stall_md}, 32'd0);
        check("hi_result", hi, expHi);
        check("lo_result", lo, expLo);
    endtask

    task automatic mtReg(input logic [2:0] op, input logic [31:0] val);
        md_valid = 1'b1;
        md_op    = op;
        rs_val   = val;
        D_useMd  = 1'b1;
        #1;
        check("stall_mt", {31'd0, stall_md}, 32'd0);
        stepEdge();
        md_valid = 1'b0;
        if (op == 3'd5) expHi = val;
        else            expLo = val;
        check("busy_mt", {31'd0, busy}, 32'd0);
        check("hi_mt", hi, expHi);
        check("lo_mt", lo, expLo);
    endtask

    task automatic noOp();
        if ($urandom_range(0, 1) == 0) begin
            md_valid = 1'b0;
            md_op    = 3'($urandom);
        end else begin
            md_valid = 1'b1;
            md_op    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
        end
        rs_val  = $urandom;
        rt_val  = $urandom;
        D_useMd = 1'($urandom);
        #1;
        check("stall_noop", {31'd0, stall_md}, 32'd0);
        stepEdge();
        md_valid = 1'b0;
        check("busy_noop", {31'd0, busy}, 32'd0);
        check("hi_noop", hi, expHi);
        check("lo_noop", lo, expLo);
    endtask

    initial begin
        reset    = 1'b0;
        md_valid = 1'b0;
        md_op    = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        D_useMd  = 1'b1;
        stepEdge();
        stepEdge();
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall", {31'd0, stall_md}, 32'd0);
        reset = 1'b1;
        stepEdge();

        // Multiply examples, signed then unsigned.
        runOp(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, -1);
        check("mult_hi_lit", hi, 32'hFFFFFFFF);
        check("mult_lo_lit", lo, 32'hFFFFFFFA);
        runOp(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, -1);
        check("multu_hi_lit", hi, 32'h00000002);
        check("multu_lo_lit", lo, 32'hFFFFFFFA);

        // Divide examples.
        runOp(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, -1);
        check("div_lo_lit", lo, 32'hFFFFFFFD);
        check("div_hi_lit", hi, 32'hFFFFFFFF);
        runOp(3'd4, 32'd7, 32'd2, 1'b0, -1);
        check("divu_lo_lit", lo, 32'd3);
        check("divu_hi_lit", hi, 32'd1);

        // Divide by zero keeps HI/LO.
        mtReg(3'd5, 32'h11);
        mtReg(3'd6, 32'h22);
        runOp(3'd3, 32'd5, 32'd0, 1'b1, -1);
        check("divzero_hi_lit", hi, 32'h11);
        check("divzero_lo_lit", lo, 32'h22);

        // Signed overflow.
        runOp(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);
        check("ovf_lo_lit", lo, 32'h80000000);
        check("ovf_hi_lit", hi, 32'h0);

        // mtlo in IDLE, then mthi dropped during a busy mult.
        mtReg(3'd6, 32'hABCD);
        check("mtlo_lit", lo, 32'hABCD);
        md_valid = 1'b1;
        md_op    = 3'd1;
        rs_val   = 32'd6;
        rt_val   = 32'd7;
        D_useMd  = 1'b1;
        stepEdge();
        md_valid = 1'b0;
        stepEdge();
        md_valid = 1'b1;
        md_op    = 3'd5;
        rs_val   = 32'hDEADBEEF;
        stepEdge();
        md_valid = 1'b0;
        repeat (3) stepEdge();
        check("mthi_ignored_hi", hi, 32'd0);
        check("mthi_ignored_lo", lo, 32'd42);
        expHi = 32'd0;
        expLo = 32'd42;

        // Reset pulsed in the middle of a multiply.
        md_valid = 1'b1;
        md_op    = 3'd1;
        rs_val   = 32'h12345;
        rt_val   = 32'h6789;
        stepEdge();
        md_valid = 1'b0;
        stepEdge();
        stepEdge();
        reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        expHi = 32'd0;
        expLo = 32'd0;
        stepEdge();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stepEdge();
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            check("post_rst_hi", hi, 32'd0);
            check("post_rst_lo", lo, 32'd0);
        end

        // Randomized mix of operations.
        for (int n = 0; n < 30; n++) begin
            int          kind;
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                op = 3'($urandom_range(1, 4));
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 7))
                    0: b = 32'd0;
                    1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                    2: b = 32'($urandom_range(1, 9));
                    default: ;
                endcase
                runOp(op, a, b, 1'($urandom),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1);
            end else if (kind <= 7) begin
                mtReg(($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6, $urandom);
            end else begin
                noOp();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
